// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register addresses FIRST_REG..LAST_REG through read
// port 1 of the 32x32 register file and presents each word on a valid/ready
// stream. It waits out the 1-cycle registered read, and it retries any read
// that was issued while the write port was active, because RD1 is high-Z then.
//
// Ports:
//   clk        rising-edge clock, shared with the register file
//   reset      asynchronous, active-high
//   start      begin a dump; sampled only while idle
//   rf_addr    read address to register file A1 (always equals the walk counter)
//   rf_we      copy of register file WE3
//   rf_rdata   register file RD1
//   out_valid  out_addr/out_data hold a valid word
//   out_ready  consumer accepts the presented word
//   out_addr   address of the presented word
//   out_data   contents of the presented register
//   busy       high from leaving IDLE until DONE exits
//   done       one-cycle pulse after the last word is accepted
module reg_dump_reader #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic              rf_we,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_HOLD    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    // The register file samples A1 directly from the walk counter.
    assign rf_addr = cnt;

    // Dump sequencer; all stream and status outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= FIRST_ADDR;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ISSUE;
                        cnt   <= FIRST_ADDR;
                        busy  <= 1'b1;
                    end
                end
                // The register file latches registers[cnt] at this edge. A
                // concurrent write turns that read into Z, so issue it again.
                S_ISSUE: begin
                    if (!rf_we) begin
                        state <= S_CAPTURE;
                    end
                end
                // RD1 now holds the word read at the previous edge.
                S_CAPTURE: begin
                    out_data  <= rf_rdata;
                    out_addr  <= cnt;
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                // Keep the word stable until the consumer takes it. The last
                // address exits before cnt is incremented, so cnt never wraps.
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cnt == LAST_ADDR) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt   <= cnt + ADDR_W'(1);
                            state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
